// File: rtl/dm_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, error codes,
// controller state and small decode helpers used by the top level.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    typedef enum logic {
        INIT,
        READY
    } dm_state_t;

    function automatic logic [3:0] size_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // The reserved size is folded into misalignment so it never reaches the array.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_bytelane_mem_if.sv
// Request/response bundle between the M stage and the data memory, plus the
// store-commit trace taps that a simulation-side printer formats.
interface dm_bytelane_mem_if;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uext;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;

    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    logic        tr_valid;
    logic [31:0] tr_pc;
    logic [31:0] tr_addr;
    logic [31:0] tr_word;

    modport master (
        output req, we, size, uext, addr, wd, pc,
        input  rdata, rvalid, err, err_code, busy,
        input  tr_valid, tr_pc, tr_addr, tr_word
    );

    modport slave (
        input  req, we, size, uext, addr, wd, pc,
        output rdata, rvalid, err, err_code, busy,
        output tr_valid, tr_pc, tr_addr, tr_word
    );

endinterface

// File: rtl/dm_lane_ext.sv
// Selects the addressed byte/half of a read word and zero- or sign-extends it.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uext,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_uext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_uext & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dm_bytelane_mem.sv
// MEM-stage data memory: byte/half/word stores via byte enables, extended
// sub-word loads with one-cycle latency, request checking and a clearing sweep.
module dm_bytelane_mem
    import dm_pkg::*;
#(
    parameter int DEPTH = 3072,
    parameter bit TRACE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    dm_bytelane_mem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    dm_state_t          r_state;
    logic [IDX_W-1:0]   r_clr_cnt;
    logic               r_busy;
    logic               r_rvalid;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [31:0]        r_rdata_hold;
    logic [1:0]         r_ld_off;
    logic [1:0]         r_ld_size;
    logic               r_ld_uext;
    logic               r_tr_valid;
    logic [31:0]        r_tr_pc;
    logic [31:0]        r_tr_addr;
    logic [3:0]         r_tr_be;
    logic [31:0]        r_tr_wdata;

    logic [IDX_W-1:0]   w_idx;
    logic               w_oor;
    logic               w_misalign;
    logic               w_accept;
    logic               w_store_ok;
    logic               w_load_ok;
    logic               w_clr_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_tr_word;
    logic [31:0]        w_ext;

    always_comb begin
        w_idx      = bus.addr[IDX_W+1:2];
        w_oor      = (|bus.addr[31:IDX_W+2]) || ({1'b0, w_idx} >= (IDX_W+1)'(DEPTH));
        w_misalign = is_misaligned(bus.size, bus.addr[1:0]);
        w_accept   = bus.req && (r_state == READY);
        w_store_ok = w_accept && bus.we && !w_misalign && !w_oor;
        w_load_ok  = w_accept && !bus.we && !w_misalign && !w_oor;
        w_clr_we   = (r_state == INIT) && reset;
        w_be       = size_be(bus.size, bus.addr[1:0]);
        case (bus.size)
            SZ_BYTE: w_wdata = {4{bus.wd[7:0]}};
            SZ_HALF: w_wdata = {2{bus.wd[15:0]}};
            default: w_wdata = bus.wd;
        endcase
    end

    // One byte-wide array per lane. Every accepted access also reads its word
    // (read-before-write), so a store's pre-write word is available for the trace merge.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] r_lane_rd;

            always_ff @(posedge clk) begin
                if (w_clr_we) begin
                    lane_mem[r_clr_cnt] <= 8'h00;
                end else if (w_store_ok && w_be[gi]) begin
                    lane_mem[w_idx] <= w_wdata[gi*8 +: 8];
                end
                if (w_load_ok || w_store_ok) begin
                    r_lane_rd <= lane_mem[w_idx];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_lane_rd;
            assign w_tr_word[gi*8 +: 8] = r_tr_be[gi] ? r_tr_wdata[gi*8 +: 8] : r_lane_rd;
        end
    endgenerate

    dm_lane_ext u_lane_ext (
        .i_word (w_rd_word),
        .i_off  (r_ld_off),
        .i_size (r_ld_size),
        .i_uext (r_ld_uext),
        .o_data (w_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= INIT;
            r_clr_cnt    <= '0;
            r_busy       <= 1'b1;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_rdata_hold <= '0;
            r_ld_off     <= '0;
            r_ld_size    <= SZ_WORD;
            r_ld_uext    <= 1'b0;
            r_tr_valid   <= 1'b0;
            r_tr_pc      <= '0;
            r_tr_addr    <= '0;
            r_tr_be      <= '0;
            r_tr_wdata   <= '0;
        end else begin
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_tr_valid <= 1'b0;
            if (r_rvalid) begin
                r_rdata_hold <= w_ext;
            end
            case (r_state)
                INIT: begin
                    if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state   <= READY;
                        r_busy    <= 1'b0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (w_accept) begin
                        if (w_misalign) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_MISALIGN;
                        end else if (w_oor) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_RANGE;
                        end else if (bus.we) begin
                            r_tr_valid <= TRACE;
                            r_tr_pc    <= bus.pc;
                            r_tr_addr  <= {bus.addr[31:2], 2'b00};
                            r_tr_be    <= w_be;
                            r_tr_wdata <= w_wdata;
                        end else begin
                            r_rvalid  <= 1'b1;
                            r_ld_off  <= bus.addr[1:0];
                            r_ld_size <= bus.size;
                            r_ld_uext <= bus.uext;
                        end
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    // rdata shows the fresh result during the rvalid pulse and holds it afterwards.
    assign bus.rdata    = r_rvalid ? w_ext : r_rdata_hold;
    assign bus.rvalid   = r_rvalid;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;
    assign bus.busy     = r_busy;
    assign bus.tr_valid = r_tr_valid;
    assign bus.tr_pc    = r_tr_pc;
    assign bus.tr_addr  = r_tr_addr;
    assign bus.tr_word  = w_tr_word;

endmodule

// File: tb/tb_dm_bytelane_mem.sv
// Scoreboard bench for dm_bytelane_mem: a byte-addressed reference model
// predicts every response and store trace; monitors compare as they appear.
module tb_dm_bytelane_mem;

    localparam int DEPTH = 3072;
    localparam bit TRACE = 1'b1;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] word;
    } tr_t;

    logic clk;
    logic reset;
    dm_bytelane_mem_if bus();

    dm_bytelane_mem #(.DEPTH(DEPTH), .TRACE(TRACE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    tr_t         tr_q[$];
    logic [7:0]  model_b [DEPTH*4];
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_word(input int base);
        return {model_b[base+3], model_b[base+2], model_b[base+1], model_b[base]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) model_b[i] = 8'h00;
    endtask

    // Reference behaviour expressed on a plain byte array, little-endian.
    task automatic model_apply(input bit w, input logic [1:0] sz, input bit ue,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
        exp_t e;
        tr_t  t;
        int   n;
        int   nbits;
        logic [31:0] v;
        bit   mis;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        e.is_err = 1'b0; e.code = 2'b00; e.data = 32'h0;
        if (mis || (a / 4) >= DEPTH) begin
            e.is_err = 1'b1;
            e.code   = mis ? 2'b01 : 2'b10;
            exp_q.push_back(e);
            return;
        end
        n = 1 << sz;
        if (w) begin
            for (int i = 0; i < n; i++) model_b[int'(a) + i] = d[8*i +: 8];
            if (TRACE) begin
                t.addr = a & ~32'h3;
                t.pc   = pc;
                t.word = model_word(int'(t.addr));
                tr_q.push_back(t);
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = model_b[int'(a) + i];
            nbits = 8 * n;
            if (n < 4 && !ue && v[nbits-1]) v = v | ~((32'h1 << nbits) - 32'h1);
            e.data = v;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int cycles);
        bus.req = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit ue,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req  = 1'b1;
        bus.we   = w;
        bus.size = sz;
        bus.uext = ue;
        bus.addr = a;
        bus.wd   = d;
        bus.pc   = pc_ctr;
        model_apply(w, sz, ue, a, d, pc_ctr);
        pc_ctr   = pc_ctr + 32'd4;
        @(negedge clk);
        bus.req  = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, DEPTH);
    endtask

    // Response monitor: every rvalid/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && (bus.rvalid === 1'b1 || bus.err === 1'b1)) begin
            if (bus.rvalid === 1'b1 && bus.err === 1'b1) begin
                tests++; fails++;
                $display("FAIL resp_both: rvalid and err together, got 1/1, expected one of them");
            end else if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL resp_unexpected: got rvalid=%0b err=%0b, expected no response",
                         bus.rvalid, bus.err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_kind_err", {31'h0, bus.err}, {31'h0, e.is_err});
                if (e.is_err) begin
                    chk("err_code", {30'h0, bus.err_code}, {30'h0, e.code});
                    $display("[TB] err code=%b", bus.err_code);
                end else begin
                    chk("rdata", bus.rdata, e.data);
                    $display("[TB] load rdata=%h", bus.rdata);
                end
            end
        end
    end

    // Trace monitor: prints each committed store and checks its merged word.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.tr_valid === 1'b1) begin
            $display("%d@%h: *%h <= %h", $time, bus.tr_pc, bus.tr_addr, bus.tr_word);
            if (tr_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL trace_unexpected: got store to %h, expected none", bus.tr_addr);
            end else begin
                tr_t t;
                t = tr_q.pop_front();
                chk("trace_addr", bus.tr_addr, t.addr);
                chk("trace_pc", bus.tr_pc, t.pc);
                chk("trace_word", bus.tr_word, t.word);
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          cnt;

        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.uext = 1'b0;
        bus.addr = 32'h0; bus.wd = 32'h0; bus.pc = 32'h0;
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h1);
        chk("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
        chk("rst_err", {31'h0, bus.err}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_err_code", {30'h0, bus.err_code}, 32'h0);
        reset = 1'b1;
        count_busy("sweep_cycles");

        // Cleared memory, then sub-word stores merged into one word.
        issue(0, 2'b10, 0, 32'h14, 32'h0);
        idle(2);
        issue(1, 2'b10, 0, 32'h10, 32'h1122_3344);
        issue(1, 2'b00, 0, 32'h11, 32'h0000_00AA);
        issue(1, 2'b01, 0, 32'h12, 32'h0000_BEEF);
        issue(0, 2'b10, 0, 32'h10, 32'h0);
        idle(2);
        chk("merged_word_model", model_word(32'h10), 32'hBEEF_AA44);

        // Sign/zero extension.
        issue(1, 2'b10, 0, 32'h20, 32'h80FF_7F01);
        issue(0, 2'b00, 0, 32'h22, 32'h0);
        issue(0, 2'b00, 1, 32'h23, 32'h0);
        issue(0, 2'b01, 0, 32'h22, 32'h0);
        issue(0, 2'b01, 1, 32'h20, 32'h0);
        issue(0, 2'b10, 1, 32'h20, 32'h0);
        idle(2);

        // Rejections and range boundary.
        issue(0, 2'b10, 0, 32'h102, 32'h0);
        issue(1, 2'b01, 0, 32'h3001, 32'h1234);
        issue(1, 2'b10, 0, 32'h3000, 32'hCAFE_F00D);
        issue(0, 2'b11, 0, 32'h40, 32'h0);
        issue(1, 2'b10, 0, 32'h2FFC, 32'h5A5A_A5A5);
        issue(0, 2'b10, 0, 32'h2FFC, 32'h0);
        issue(0, 2'b10, 0, 32'h8000_0000, 32'h0);
        idle(2);

        // Store-to-load forwarding through the array and back-to-back loads.
        issue(1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF);
        issue(0, 2'b10, 0, 32'h40, 32'h0);
        issue(0, 2'b10, 0, 32'h10, 32'h0);
        issue(0, 2'b10, 0, 32'h20, 32'h0);
        issue(0, 2'b00, 0, 32'h43, 32'h0);
        idle(3);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h3000 + $urandom_range(0, 15);
            else if (r == 1) a = $urandom;
            else             a = $urandom_range(0, 255);
            issue($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        // Reset part-way through a sweep; requests during busy must vanish.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (1000) @(negedge clk);
        chk("midsweep_busy", {31'h0, bus.busy}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 5000) begin
            bus.req = (cnt == 10 || cnt == 11 || cnt == 2000);
            bus.we  = (cnt != 11);
            bus.size = 2'b10;
            bus.uext = 1'b0;
            bus.addr = (cnt == 11) ? 32'h10 : 32'h14;
            bus.wd   = 32'h7777_7777;
            cnt++;
            @(negedge clk);
        end
        bus.req = 1'b0;
        chk("resweep_cycles", cnt, DEPTH);
        issue(0, 2'b10, 0, 32'h14, 32'h0);
        issue(0, 2'b10, 0, 32'h10, 32'h0);
        idle(4);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("tr_q_drained", tr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_bytelane_mem.md
Name: dm_bytelane_mem

Overview:
- Parametrised data memory for the MEM stage.
- Successor to the word-only DM: adds byte/half/word stores with byte enables, and signed/unsigned sub-word loads.
- Adds registered reads (1-cycle latency, pipelined), misalignment and range checking, and a post-reset clearing sweep with a busy flag.
- Sits between the M-stage ALU result and the M/W pipeline register; store trace output format is unchanged.

Parameters:
- DEPTH, 3072, number of 32-bit words.
- IDX_W, $clog2(DEPTH), derived localparam; word index = addr[IDX_W+1:2].
- TRACE, 1, when 1 every committed store prints a trace line.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request valid; accepted only when busy=0.
- we  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- uext  in  1  loads only: 1=zero-extend, 0=sign-extend.
- addr  in  32  byte address.
- wd  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- pc  in  32  instruction PC, used for the trace only.
- rdata  out  32  load result, extended to 32 bits.
- rvalid  out  1  1-cycle pulse; rdata is valid.
- err  out  1  1-cycle pulse; the request was rejected.
- err_code  out  2  01 misaligned, 10 out of range; valid when err=1.
- busy  out  1  clearing sweep in progress.

Behaviour:
Reset (reset=0, async):
- state=INIT, clr_cnt=0, busy=1.
- rvalid=0, err=0, rdata=0, err_code=0.
- Memory contents are not touched asynchronously.

INIT state:
- Each clk writes 0 to word clr_cnt, then clr_cnt++.
- After writing word DEPTH-1, go to READY; busy=0 from the next cycle. Total is exactly DEPTH cycles with busy=1.
- reset asserted mid-sweep restarts the sweep from 0.
- req during busy=1 is ignored: no write, no rvalid, no err.

READY, accepted request (req=1, busy=0):
- Misaligned if size=01 and addr[0]=1, size=10 and addr[1:0]!=0, or size=11.
- Out of range if addr[31:IDX_W+2]!=0 or index>=DEPTH.
- Misalignment takes priority when both apply.
- On error: no write; next cycle err=1 with err_code; rvalid stays 0.
- Store:
  - Byte enables: byte→be=1<<addr[1:0]; half→be=2'b11<<addr[1:0]; word→1111.
  - Lanes are replicated: byte→{4{wd[7:0]}}, half→{2{wd[15:0]}}.
  - Only enabled bytes are written, at the rising edge.
  - If TRACE, print "%d@%h: *%h <= %h" with $time, pc, {addr[31:2],2'b00} and the full merged post-write word.
  - No rvalid for stores.
- Load:
  - Read the word at the edge; next cycle rvalid=1.
  - rdata = selected lane (byte by addr[1:0], half by addr[1]), zero- or sign-extended per uext.
  - Word loads ignore uext.
- Back-to-back loads: one result per cycle, in order.
- Store then load to the same word on the next cycle: the load returns the post-store value.
- Same-cycle read/write is impossible (one request per cycle).
- rdata holds its last value while rvalid=0.
- No request: rvalid=0, err=0.

Decomposition:
- Package dm_pkg:
  - SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD encodings.
  - ERR_NONE, ERR_MISALIGN, ERR_RANGE codes.
  - State enum {INIT, READY}.
- One combinational sub-module, dm_lane_ext:
  - inputs: word, addr[1:0], size, uext.
  - output: extended 32-bit load result.
  - Instanced on the registered read path.
- Byte-enable generation and the FSM stay in the top level.

Test Plan:
- Reset sweep: pulse reset low at t=0, then hold high. busy=1 for exactly 3072 cycles. A load at word 5 right after busy falls returns rdata=0 with rvalid one cycle later.
- Byte/half stores: sw 0x11223344 @0x10, then sb wd=0xAA @0x11, then sh wd=0xBEEF @0x12. lw @0x10 returns 0xBEEFAA44. Trace lines show words 0x1122AA44 and then 0xBEEFAA44 at *00000010.
- Extension: with word 0x80FF7F01 @0x20:
  - lb @0x22 uext=0 → 0xFFFFFFFF
  - lbu @0x23 → 0x00000080
  - lh @0x22 → 0xFFFF80FF
  - lhu @0x20 → 0x00007F01
- Errors:
  - lw @0x102 → err=1, code 01, no rvalid.
  - sh @0x3001 → code 01, memory unchanged.
  - sw @0x3000 (index 3072) → code 10, no trace line.
- Pipelining/hazard: sw 0xDEADBEEF @0x40, then lw @0x40 next cycle → 0xDEADBEEF. Three consecutive lw → three consecutive rvalid pulses in order.
- Reset mid-sweep: reset at sweep cycle 1000 → busy stays 1 for a further full 3072 cycles. A req during busy produces no rvalid, no err, no write.
